alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, operand/result width in bits.
REQ-002 SHALL have ports clk (in, 1) and rst_n (in, 1); one clock, and reset is synchronous and active-low.
REQ-003 SHALL have, for each requester k in {0,1}:
- reqk_valid (in, 1): request pending.
- reqk_ready (out, 1): request accepted this cycle.
- reqk_a (in, N) and reqk_b (in, N): operands.
- reqk_op (in, 4): ALU selector.
- reqk_cin (in, 1): carry-in.
REQ-004 SHALL have rsp0_valid and rsp1_valid (out, 1 each): response for that requester.
REQ-005 SHALL have shared response ports: rsp_ready (in, 1), rsp_z (out, N), rsp_co (out, 1), rsp_err (out, 1).
REQ-006 SHALL have ALU-side ports:
- alu_a (out, N), alu_b (out, N), alu_cin (out, 1), alu_sel (out, 4): drive the ALU.
- alu_z (in, N), alu_co (in, 1): combinational ALU result.

Function
REQ-007 SHALL implement FSM states IDLE, EXEC and RESP.
REQ-008 In IDLE, SHALL grant at most one requester per cycle, round-robin.
- Priority pointer resets to 0.
- After a grant to k, priority passes to the other requester.
REQ-009 SHALL assert reqk_ready only in IDLE, and only for the granted k.
- Acceptance is the cycle in which reqk_valid and reqk_ready are both high.
- On acceptance, SHALL register a, b, op, cin and the grant id, then go to EXEC.
REQ-010 In EXEC, SHALL drive alu_a, alu_b, alu_sel and alu_cin from the registered operands.
- SHALL capture alu_z and alu_co at the end of the cycle.
- SHALL then go to RESP.
REQ-011 Legal op codes are 0000 add, 0001 sub, 0011 and, 0100 or, 0101 xor, 1001 shift-left-arithmetic.
- Any other op SHALL capture rsp_z=0, rsp_co=0, rsp_err=1.
- The ALU is still driven but its result is ignored.
REQ-012 In RESP, SHALL assert rspk_valid for the granted k only.
- rsp_z, rsp_co and rsp_err SHALL be held stable until rsp_ready=1.
- The FSM then returns to IDLE.
REQ-013 Minimum latency from acceptance to rspk_valid SHALL be 2 cycles.
- Throughput SHALL be one operation per 3 cycles.
REQ-014 When no operation is in flight, alu_* outputs SHALL be 0.
REQ-015 SHALL deassert both reqk_ready outside IDLE.
- A requester that drops reqk_valid before acceptance SHALL lose its grant with no side effect.

Reset
REQ-016 While rst_n=0 at a clk edge, SHALL set:
- state to IDLE and the pointer to 0.
- all registered operands to 0.
- rspk_valid=0, rsp_z=0, rsp_co=0, rsp_err=0.
REQ-017 Reset during EXEC or RESP SHALL abort the operation.
- No response SHALL be issued for the aborted operation.

Configuration
REQ-018 Macro ALU_FLAGS_EN SHALL control an extra output port rsp_zf (out, 1).
- With ALU_FLAGS_EN defined, rsp_zf is present and registered with the result.
- rsp_zf SHALL be 1 iff the captured rsp_z==0 and rsp_err=0.
- rsp_zf resets to 0 and is held like rsp_z.
- Without ALU_FLAGS_EN, the port and its logic SHALL be absent.

Verification
REQ-019 Add on requester 0, N=4:
- Stimulus: req0 a=0001, b=1010, op=0000, cin=0, rsp_ready=1.
- Response: rsp0_valid 2 cycles after acceptance, rsp_z=1011, rsp_co=0, rsp_err=0.
REQ-020 Contention after reset:
- Stimulus: req0 op=0011 (a=1001, b=0110) and req1 op=0100 (a=1001, b=0110) both valid.
- Response: req0 served first with rsp_z=0000, then req1 with rsp_z=1111.
- Next contention SHALL grant req0 again only after req1 has been served.
REQ-021 Backpressure:
- Stimulus: rsp_ready=0 for 3 cycles in RESP.
- Response: rsp_z, rsp_co and rspk_valid stable; both reqk_ready=0; release on rsp_ready=1.
REQ-022 Illegal op:
- Stimulus: op=1111.
- Response: rsp_err=1, rsp_z=0000, rsp_co=0.
- With ALU_FLAGS_EN defined, rsp_zf=0.
REQ-023 Reset mid-operation:
- Stimulus: rst_n=0 for 1 cycle during EXEC.
- Response: IDLE next cycle, no rspk_valid, pointer 0, all outputs 0.
REQ-024 Zero flag and carry, with ALU_FLAGS_EN defined:
- Stimulus: xor a=0001, b=0001.
- Response: rsp_z=0000, rsp_zf=1.
- Stimulus: sub a=1010, b=0001.
- Response: rsp_zf=0 and rsp_co matching the ALU output.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one combinational ALU between two requesters:
// IDLE grants, EXEC drives the ALU and captures its result, RESP holds it until rsp_ready.
// Define ALU_FLAGS_EN to add the registered zero-flag output rsp_zf.

module alu_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [3:0]   req0_op,
  input  logic         req0_cin,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic [3:0]   req1_op,
  input  logic         req1_cin,
  output logic         rsp0_valid,
  output logic         rsp1_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_z,
  output logic         rsp_co,
  output logic         rsp_err,
`ifdef ALU_FLAGS_EN
  output logic         rsp_zf,
`endif
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic         alu_cin,
  output logic [3:0]   alu_sel,
  input  logic [N-1:0] alu_z,
  input  logic         alu_co
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_SLA = 4'b1001;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLA: op_legal = 1'b1;
      default:                                      op_legal = 1'b0;
    endcase
  endfunction

  state_e       state_q, state_d;
  logic         ptr_q, ptr_d;
  logic         id_q, id_d;
  logic [N-1:0] a_q, a_d;
  logic [N-1:0] b_q, b_d;
  logic [3:0]   op_q, op_d;
  logic         cin_q, cin_d;
  logic [N-1:0] z_q, z_d;
  logic         co_q, co_d;
  logic         err_q, err_d;
`ifdef ALU_FLAGS_EN
  logic         zf_q, zf_d;
`endif

  // With both requesters pending the pointer decides; otherwise the lone requester wins.
  logic gnt_any;
  logic gnt_id;
  logic accept;

  always_comb begin
    gnt_any = req0_valid | req1_valid;
    gnt_id  = (req0_valid & req1_valid) ? ptr_q : req1_valid;
    accept  = (state_q == IDLE) & gnt_any;
  end

  // State register (plus the datapath flops that travel with it).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: operand and result registers are cleared too, so an aborted
      // operation leaves nothing stale on rsp_z or for the next EXEC.
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      id_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      cin_q   <= 1'b0;
      z_q     <= '0;
      co_q    <= 1'b0;
      err_q   <= 1'b0;
`ifdef ALU_FLAGS_EN
      zf_q    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values.
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cin_q   <= cin_d;
      z_q     <= z_d;
      co_q    <= co_d;
      err_q   <= err_d;
`ifdef ALU_FLAGS_EN
      zf_q    <= zf_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first, so no path through the case leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: latch the granted request, then capture the ALU result.
  always_comb begin
    ptr_d = ptr_q;
    id_d  = id_q;
    a_d   = a_q;
    b_d   = b_q;
    op_d  = op_q;
    cin_d = cin_q;
    z_d   = z_q;
    co_d  = co_q;
    err_d = err_q;
`ifdef ALU_FLAGS_EN
    zf_d  = zf_q;
`endif
    if (accept) begin
      ptr_d = ~gnt_id;
      id_d  = gnt_id;
      a_d   = gnt_id ? req1_a   : req0_a;
      b_d   = gnt_id ? req1_b   : req0_b;
      op_d  = gnt_id ? req1_op  : req0_op;
      cin_d = gnt_id ? req1_cin : req0_cin;
    end
    if (state_q == EXEC) begin
      if (op_legal(op_q)) begin
        z_d   = alu_z;
        co_d  = alu_co;
        err_d = 1'b0;
      end else begin
        z_d   = '0;
        co_d  = 1'b0;
        err_d = 1'b1;
      end
`ifdef ALU_FLAGS_EN
      zf_d = op_legal(op_q) && (alu_z == '0);
`endif
    end
  end

  // Outputs: ALU is driven only in EXEC, responses only in RESP.
  always_comb begin
    req0_ready = accept & ~gnt_id;
    req1_ready = accept &  gnt_id;
    rsp0_valid = (state_q == RESP) & ~id_q;
    rsp1_valid = (state_q == RESP) &  id_q;
    rsp_z      = z_q;
    rsp_co     = co_q;
    rsp_err    = err_q;
`ifdef ALU_FLAGS_EN
    rsp_zf     = zf_q;
`endif
    alu_a      = '0;
    alu_b      = '0;
    alu_sel    = '0;
    alu_cin    = 1'b0;
    if (state_q == EXEC) begin
      alu_a   = a_q;
      alu_b   = b_q;
      alu_sel = op_q;
      alu_cin = cin_q;
    end
  end

endmodule
